// File: rtl/spi_tx_serializer.sv
// SPI mode-0 transmit serializer on the read side of the SPI word FIFO.
// Pops one word per frame and shifts it out on sclk/mosi, framed by cs_n.
module spi_tx_serializer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CS_GAP    = 2,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             fifo_rempty_i,
    output logic             fifo_rinc_o,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    output logic             spi_sclk_o,
    output logic             spi_mosi_o,
    output logic             spi_cs_n_o,
    output logic             busy_o,
    output logic             word_done_o
);

    localparam int unsigned DivW = $clog2(CLK_DIV + 1);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned GapW = $clog2(CS_GAP + 1);

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              word_done_q, word_done_d;

    logic              div_tick;
    logic              last_fall;
    logic              first_bit;
    logic              next_bit;
    logic [WIDTH-1:0]  shreg_shifted;

    assign div_tick  = (state_q == StShift) && (div_cnt_q == DivLast);
    // Falling toggle of the final bit closes the frame.
    assign last_fall = div_tick && sclk_q && (bit_cnt_q == '0);

    assign first_bit     = (MSB_FIRST != 0) ? fifo_rdata_i[WIDTH-1] : fifo_rdata_i[0];
    assign next_bit      = (MSB_FIRST != 0) ? shreg_q[WIDTH-2] : shreg_q[1];
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg_q[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fifo_rinc_o) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (last_fall) state_d = StGap;
            StGap:   if (gap_cnt_q == GapLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic.
    always_comb begin
        fifo_rinc_o = (state_q == StIdle) && enable_i && !fifo_rempty_i;
        busy_o      = (state_q != StIdle);
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        word_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
            end
            StLoad: begin
                shreg_d   = fifo_rdata_i;
                cs_n_d    = 1'b0;
                sclk_d    = 1'b0;
                mosi_d    = first_bit;
                bit_cnt_d = BitLast;
                div_cnt_d = '0;
            end
            StShift: begin
                if (div_tick) begin
                    div_cnt_d = '0;
                    sclk_d    = !sclk_q;
                    // Data only moves on the falling toggle; rising toggle is the sample point.
                    if (sclk_q) begin
                        if (bit_cnt_q == '0) begin
                            cs_n_d      = 1'b1;
                            mosi_d      = 1'b0;
                            word_done_d = 1'b1;
                            gap_cnt_d   = '0;
                        end else begin
                            shreg_d   = shreg_shifted;
                            mosi_d    = next_bit;
                            bit_cnt_d = bit_cnt_q - 1'b1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StGap: begin
                cs_n_d    = 1'b1;
                sclk_d    = 1'b0;
                mosi_d    = 1'b0;
                gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and registered SPI outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            word_done_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            word_done_q <= word_done_d;
        end
    end

    assign spi_sclk_o  = sclk_q;
    assign spi_mosi_o  = mosi_q;
    assign spi_cs_n_o  = cs_n_q;
    assign word_done_o = word_done_q;

endmodule
